// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the two-requester ALU arbiter.
//   state_e     - arbiter FSM states
//   ALU_OP_*    - opcodes the arbiter itself needs to recognise
//   op_meta_t   - latched per-op control fields (operand mux, opcode, owner)
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [4:0] ALU_OP_PASS = 5'b00000;
   localparam logic [4:0] ALU_OP_ADDC = 5'b00001;

   typedef struct packed {
      logic       sel;
      logic [4:0] op;
      logic       id;
   } op_meta_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin grant with its pointer.
//   clk, rst_n - clock, async active-low reset (pointer -> 0)
//   en         - arbitration allowed this cycle
//   req[1:0]   - request vector
//   gnt[1:0]   - one-hot grant (combinational), zero when !en
//   gnt_id     - index of the winner (valid whenever gnt != 0)
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic ptr;

   // Pointer only matters under contention; a lone requester always wins.
   always_comb begin
      gnt_id = (req == 2'b11) ? ptr : req[1];
      gnt    = 2'b00;
      if (en && (|req)) gnt[gnt_id] = 1'b1;
   end

   // After any grant the pointer names the requester that did not win.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr <= 1'b0;
      else if (|gnt)   ptr <= ~gnt_id;
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
//   req0_*/req1_* - valid/ready op requests (a, b, sel, op)
//   alu_*         - drive to / results from the shared ALU
//   rsp_*         - valid/ready response: result, flags, requester id
// Flow: IDLE grants one requester and latches its op, EXEC presents it to
// the ALU for one cycle and captures the result, RESP holds it until taken.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sel,
   input  logic [4:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sel,
   input  logic [4:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_sel,
   output logic [4:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   input  logic             alu_zero,
   input  logic             alu_sign,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             rsp_sign
);

   state_e           state;
   logic [1:0]       gnt;
   logic             gnt_id;
   logic             acc;
   logic             arb_en;
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   op_meta_t         lat;

   // Gating with rst_n keeps ready low while reset is held, even though the
   // state register already reads IDLE.
   assign arb_en = rst_n && (state == IDLE);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (arb_en),
      .req    ({req1_valid, req0_valid}),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign acc        = |gnt;
   assign rsp_valid  = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (acc) state <= EXEC;
            EXEC:    state <= RESP;
            RESP:    if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_a <= '0;
         lat_b <= '0;
         lat   <= '0;
      end else if (acc) begin
         lat_a <= gnt_id ? req1_a : req0_a;
         lat_b <= gnt_id ? req1_b : req0_b;
         lat   <= '{sel: (gnt_id ? req1_sel : req0_sel),
                    op:  (gnt_id ? req1_op  : req0_op),
                    id:  gnt_id};
      end
   end

   // The ALU sees the latched op only during EXEC; otherwise a zero pass.
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = 1'b0;
      alu_op  = ALU_OP_PASS;
      if (state == EXEC) begin
         alu_a   = lat_a;
         alu_b   = lat_b;
         alu_sel = lat.sel;
         alu_op  = lat.op;
      end
   end

   // Capture at the end of EXEC. The ALU carry output is sticky across ops,
   // so it is only meaningful for add-with-carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_sign   <= 1'b0;
      end else if (state == EXEC) begin
         rsp_id     <= lat.id;
         rsp_result <= alu_result;
         rsp_carry  <= (lat.op == ALU_OP_ADDC) && alu_carry;
         rsp_zero   <= alu_zero;
         rsp_sign   <= alu_sign;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural
// stand-in ALU (sticky carry) and a transaction-level reference model.
module tb_alu_arbiter;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sel;
      logic [4:0]   op;
   } req_t;

   typedef struct packed {
      logic         rdy0, rdy1;
      logic         ex_rdy, ex_rv;
      logic [W-1:0] ex_a, ex_b;
      logic         ex_sel;
      logic [4:0]   ex_op;
      logic         rv, id, carry, zero, sign;
      logic [W-1:0] result;
      logic         rs_rdy, stable, post_rv, post_rdy;
      logic [W-1:0] idle_a;
   } obs_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, req0_sel;
   logic [W-1:0] req0_a, req0_b;
   logic [4:0]   req0_op;
   logic         req1_valid, req1_ready, req1_sel;
   logic [W-1:0] req1_a, req1_b;
   logic [4:0]   req1_op;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic         alu_sel, alu_carry, alu_zero, alu_sign;
   logic [4:0]   alu_op;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0] rsp_result;
   logic         rsp_carry, rsp_zero, rsp_sign;

   int   errors = 0;
   int   checks = 0;
   logic m_ptr  = 1'b0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_sel(req0_sel), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_sel(req1_sel), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_op(alu_op),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .alu_sign(alu_sign),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
      .rsp_sign(rsp_sign)
   );

   // ALU semantics: sel replaces operand A by 1; bit W is the add carry.
   function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sel, input logic [4:0] op);
      logic [W-1:0] x;
      x = sel ? W'(1) : a;
      case (op)
         5'd0:    alu_f = {1'b0, x};
         5'd1:    alu_f = {1'b0, x} + {1'b0, b};
         5'd2:    alu_f = {1'b0, x & b};
         5'd3:    alu_f = {1'b0, x | b};
         5'd4:    alu_f = {1'b0, x ^ b};
         5'd5:    alu_f = {1'b0, x + ~b};
         default: alu_f = '0;
      endcase
   endfunction

   // Stand-in ALU: its carry output keeps the last add carry for other ops.
   logic [W:0] alu_full;
   logic       held_carry = 1'b1;
   assign alu_full   = alu_f(alu_a, alu_b, alu_sel, alu_op);
   assign alu_result = alu_full[W-1:0];
   assign alu_carry  = (alu_op == 5'd1) ? alu_full[W] : held_carry;
   assign alu_zero   = (alu_full[W-1:0] == '0);
   assign alu_sign   = alu_full[W-1];
   always @(posedge clk) if (alu_op == 5'd1) held_carry <= alu_full[W];

   // Round-robin reference: lone requester wins, contention goes to pointer.
   function automatic logic model_grant(input logic v0, input logic v1);
      logic g;
      g = (v0 && v1) ? m_ptr : v1;
      m_ptr = ~g;
      return g;
   endfunction

   // Drives one transaction from IDLE and records what the DUT shows at each
   // phase. Entered and left at 1 time unit after a rising edge.
   task automatic txn(input logic v0, input logic v1, input req_t q0, input req_t q1,
                      input int stall, input bit keep, output obs_t o);
      o = '0;
      o.stable = 1'b1;
      req0_valid = v0; req0_a = q0.a; req0_b = q0.b; req0_sel = q0.sel; req0_op = q0.op;
      req1_valid = v1; req1_a = q1.a; req1_b = q1.b; req1_sel = q1.sel; req1_op = q1.op;
      #1;
      o.rdy0 = req0_ready;
      o.rdy1 = req1_ready;
      if (!(o.rdy0 || o.rdy1)) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      rsp_ready = (stall == 0);
      #1;
      o.ex_rdy = req0_ready | req1_ready;
      o.ex_rv  = rsp_valid;
      o.ex_a   = alu_a;  o.ex_b  = alu_b;
      o.ex_sel = alu_sel; o.ex_op = alu_op;
      @(posedge clk); #1;
      o.rv = rsp_valid; o.id = rsp_id; o.result = rsp_result;
      o.carry = rsp_carry; o.zero = rsp_zero; o.sign = rsp_sign;
      o.rs_rdy = req0_ready | req1_ready;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_id !== o.id || rsp_result !== o.result ||
             rsp_carry !== o.carry || rsp_zero !== o.zero || rsp_sign !== o.sign ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) o.stable = 1'b0;
         if (i == stall - 1) rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      o.post_rv  = rsp_valid;
      o.post_rdy = req0_ready | req1_ready;
      o.idle_a   = alu_a;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      m_ptr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h55; req0_b = 32'h66; req0_sel = 1'b1; req0_op = 5'd3;
      req1_valid = 1'b1; req1_a = 32'h77; req1_b = 32'h88; req1_sel = 1'b1; req1_op = 5'd4;
      #2;
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if ({rsp_id, rsp_carry, rsp_zero, rsp_sign} !== 4'b0) begin errors++; $display("FAIL reset_rsp_bits got=%b exp=0000", {rsp_id, rsp_carry, rsp_zero, rsp_sign}); end
      checks++; if (rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result got=%0h exp=0", rsp_result); end
      checks++; if ({alu_a, alu_b, alu_sel, alu_op} !== '0) begin errors++; $display("FAIL reset_alu got=%0h exp=0", {alu_a, alu_b, alu_sel, alu_op}); end
      do_reset();
   endtask

   task automatic test_single();
      obs_t o; logic g;
      g = model_grant(1'b1, 1'b0);
      txn(1'b1, 1'b0, '{a: 32'd5, b: 32'd7, sel: 1'b0, op: 5'd1}, '0, 0, 1'b0, o);
      checks++; if ({o.rdy0, o.rdy1} !== {~g, g}) begin errors++; $display("FAIL single_ready got=%b exp=%b", {o.rdy0, o.rdy1}, {~g, g}); end
      checks++; if ({o.ex_a, o.ex_b, o.ex_sel, o.ex_op} !== {32'd5, 32'd7, 1'b0, 5'd1}) begin errors++; $display("FAIL single_alu_drive got=%0h/%0h/%b/%0h exp=5/7/0/1", o.ex_a, o.ex_b, o.ex_sel, o.ex_op); end
      checks++; if (o.ex_rv !== 1'b0) begin errors++; $display("FAIL single_exec_valid got=%b exp=0", o.ex_rv); end
      checks++; if (o.rv !== 1'b1) begin errors++; $display("FAIL single_latency got=%b exp=1", o.rv); end
      checks++; if ({o.id, o.result} !== {1'b0, 32'd12}) begin errors++; $display("FAIL single_result got=%0d/%0d exp=0/12", o.id, o.result); end
      checks++; if ({o.carry, o.zero, o.sign} !== 3'b000) begin errors++; $display("FAIL single_flags got=%b exp=000", {o.carry, o.zero, o.sign}); end
      checks++; if ({o.post_rv, o.idle_a} !== '0) begin errors++; $display("FAIL single_idle got=%b/%0h exp=0/0", o.post_rv, o.idle_a); end
   endtask

   task automatic test_contention();
      obs_t o; logic g;
      logic [2:0] exp_ids;
      req_t q0, q1, qg;
      logic [W:0] e;
      exp_ids = 3'b010;
      do_reset();
      q0 = '{a: 32'h100, b: 32'h23, sel: 1'b0, op: 5'd4};
      q1 = '{a: 32'hF0F0, b: 32'h0FF0, sel: 1'b0, op: 5'd3};
      for (int k = 0; k < 3; k++) begin
         g = model_grant(1'b1, 1'b1);
         qg = g ? q1 : q0;
         e = alu_f(qg.a, qg.b, qg.sel, qg.op);
         txn(1'b1, 1'b1, q0, q1, 0, 1'b1, o);
         checks++; if ({o.rdy0, o.rdy1} !== {~exp_ids[k], exp_ids[k]}) begin errors++; $display("FAIL contend_ready[%0d] got=%b exp=%b", k, {o.rdy0, o.rdy1}, {~exp_ids[k], exp_ids[k]}); end
         checks++; if (o.id !== exp_ids[k]) begin errors++; $display("FAIL contend_id[%0d] got=%0d exp=%0d", k, o.id, exp_ids[k]); end
         checks++; if (o.result !== e[W-1:0]) begin errors++; $display("FAIL contend_result[%0d] got=%0h exp=%0h", k, o.result, e[W-1:0]); end
         checks++; if ({o.ex_rdy, o.rs_rdy, o.post_rdy} !== 3'b001) begin errors++; $display("FAIL contend_ready_phases[%0d] got=%b exp=001", k, {o.ex_rdy, o.rs_rdy, o.post_rdy}); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_carry();
      obs_t o; logic g;
      g = model_grant(1'b0, 1'b1);
      txn(1'b0, 1'b1, '0, '{a: 32'hFFFFFFFF, b: 32'd1, sel: 1'b0, op: 5'd1}, 0, 1'b0, o);
      checks++; if ({o.id, o.result} !== {g, 32'd0}) begin errors++; $display("FAIL carry_add_result got=%0d/%0h exp=%0d/0", o.id, o.result, g); end
      checks++; if ({o.carry, o.zero, o.sign} !== 3'b110) begin errors++; $display("FAIL carry_add_flags got=%b exp=110", {o.carry, o.zero, o.sign}); end
      g = model_grant(1'b0, 1'b1);
      txn(1'b0, 1'b1, '0, '{a: 32'hF0F0, b: 32'hFF, sel: 1'b0, op: 5'd2}, 0, 1'b0, o);
      checks++; if (o.result !== 32'hF0) begin errors++; $display("FAIL carry_and_result got=%0h exp=f0", o.result); end
      checks++; if ({o.carry, o.zero, o.sign} !== 3'b000) begin errors++; $display("FAIL carry_and_flags got=%b exp=000", {o.carry, o.zero, o.sign}); end
   endtask

   task automatic test_back_to_back();
      obs_t o; logic g;
      req_t q0, q1, qg;
      logic [W:0] e;
      q0 = '{a: 32'h1234, b: 32'h1111, sel: 1'b0, op: 5'd1};
      q1 = '{a: 32'h8000_0000, b: 32'h7, sel: 1'b0, op: 5'd0};
      g = model_grant(1'b1, 1'b1);
      qg = g ? q1 : q0;
      e = alu_f(qg.a, qg.b, qg.sel, qg.op);
      txn(1'b1, 1'b1, q0, q1, 5, 1'b1, o);
      checks++; if ({o.id, o.result} !== {g, e[W-1:0]}) begin errors++; $display("FAIL bp_result got=%0d/%0h exp=%0d/%0h", o.id, o.result, g, e[W-1:0]); end
      checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL bp_stable got=%b exp=1", o.stable); end
      checks++; if ({o.rs_rdy, o.post_rv, o.post_rdy} !== 3'b001) begin errors++; $display("FAIL bp_resume got=%b exp=001", {o.rs_rdy, o.post_rv, o.post_rdy}); end
      g = model_grant(1'b1, 1'b1);
      qg = g ? q1 : q0;
      e = alu_f(qg.a, qg.b, qg.sel, qg.op);
      txn(1'b1, 1'b1, q0, q1, 0, 1'b0, o);
      checks++; if ({o.id, o.result, o.sign} !== {g, e[W-1:0], e[W-1]}) begin errors++; $display("FAIL bp_second got=%0d/%0h/%b exp=%0d/%0h/%b", o.id, o.result, o.sign, g, e[W-1:0], e[W-1]); end
   endtask

   task automatic test_reset_exec();
      obs_t o; logic g;
      req_t q;
      q = '{a: 32'hABCD, b: 32'h1, sel: 1'b0, op: 5'd1};
      g = model_grant(1'b1, 1'b0);
      txn(1'b1, 1'b0, '{a: 32'h9, b: 32'h6, sel: 1'b0, op: 5'd4}, '0, 0, 1'b0, o);
      checks++; if (o.result !== 32'hF) begin errors++; $display("FAIL rexec_pre got=%0h exp=f", o.result); end
      req0_valid = 1'b1; req0_a = q.a; req0_b = q.b; req0_sel = q.sel; req0_op = q.op;
      @(posedge clk); #1;
      checks++; if (alu_a !== q.a) begin errors++; $display("FAIL rexec_in_exec got=%0h exp=%0h", alu_a, q.a); end
      rst_n = 1'b0;
      #1;
      checks++; if ({rsp_valid, req0_ready, alu_op, alu_a, rsp_result} !== '0) begin errors++; $display("FAIL rexec_forced got=%b/%b/%0h/%0h/%0h exp=0", rsp_valid, req0_ready, alu_op, alu_a, rsp_result); end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         checks++; if ({rsp_valid, req0_ready} !== 2'b00) begin errors++; $display("FAIL rexec_held[%0d] got=%b exp=00", k, {rsp_valid, req0_ready}); end
      end
      req0_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      m_ptr = 1'b0;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_no_rsp got=%b exp=0", rsp_valid); end
      g = model_grant(1'b1, 1'b1);
      txn(1'b1, 1'b1, q, '{a: 32'h5, b: 32'h5, sel: 1'b0, op: 5'd2}, 0, 1'b0, o);
      checks++; if ({o.rdy0, o.rdy1, o.id} !== {~g, g, g} || g !== 1'b0) begin errors++; $display("FAIL rexec_ptr got=%b exp=100", {o.rdy0, o.rdy1, o.id}); end
      checks++; if ({o.result, o.carry} !== {32'hABCE, 1'b0}) begin errors++; $display("FAIL rexec_reissue got=%0h/%b exp=abce/0", o.result, o.carry); end
   endtask

   task automatic test_sign();
      obs_t o; logic g;
      g = model_grant(1'b1, 1'b0);
      txn(1'b1, 1'b0, '{a: $urandom, b: 32'd3, sel: 1'b1, op: 5'd5}, '0, 0, 1'b0, o);
      checks++; if ({o.id, o.result} !== {g, 32'hFFFFFFFD}) begin errors++; $display("FAIL sign_result got=%0d/%0h exp=%0d/fffffffd", o.id, o.result, g); end
      checks++; if ({o.ex_sel, o.ex_op} !== {1'b1, 5'd5}) begin errors++; $display("FAIL sign_drive got=%b/%0h exp=1/5", o.ex_sel, o.ex_op); end
      checks++; if ({o.carry, o.zero, o.sign} !== 3'b001) begin errors++; $display("FAIL sign_flags got=%b exp=001", {o.carry, o.zero, o.sign}); end
   endtask

   task automatic test_random();
      obs_t o; logic g, v0, v1;
      req_t q0, q1, qg;
      logic [W:0] e;
      logic [2:0] ef;
      int st;
      for (int i = 0; i < 40; i++) begin
         {v1, v0} = 2'($urandom_range(1, 3));
         q0 = '{a: $urandom, b: $urandom, sel: 1'($urandom), op: 5'($urandom_range(0, 7))};
         q1 = '{a: $urandom, b: $urandom, sel: 1'($urandom), op: 5'($urandom_range(0, 7))};
         if ($urandom_range(0, 4) == 0) q0.op = 5'($urandom);
         if (i % 5 == 0) q1.b = '0;
         st = $urandom_range(0, 2);
         g = model_grant(v0, v1);
         qg = g ? q1 : q0;
         e = alu_f(qg.a, qg.b, qg.sel, qg.op);
         ef = {(qg.op == 5'd1) & e[W], e[W-1:0] == '0, e[W-1]};
         txn(v0, v1, q0, q1, st, 1'b0, o);
         checks++; if ({o.rdy0, o.rdy1} !== {~g, g}) begin errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, {o.rdy0, o.rdy1}, {~g, g}); end
         checks++; if ({o.ex_a, o.ex_b, o.ex_sel, o.ex_op} !== {qg.a, qg.b, qg.sel, qg.op}) begin errors++; $display("FAIL rand_drive[%0d] got=%0h/%0h exp=%0h/%0h", i, o.ex_a, o.ex_op, qg.a, qg.op); end
         checks++; if ({o.rv, o.id, o.result} !== {1'b1, g, e[W-1:0]}) begin errors++; $display("FAIL rand_result[%0d] got=%b/%0d/%0h exp=1/%0d/%0h", i, o.rv, o.id, o.result, g, e[W-1:0]); end
         checks++; if ({o.carry, o.zero, o.sign} !== ef) begin errors++; $display("FAIL rand_flags[%0d] got=%b exp=%b", i, {o.carry, o.zero, o.sign}, ef); end
         checks++; if ({o.stable, o.post_rv} !== 2'b10) begin errors++; $display("FAIL rand_hold[%0d] got=%b exp=10", i, {o.stable, o.post_rv}); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = 1'b0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = 1'b0; req1_op = '0;
      test_reset();
      test_single();
      test_contention();
      test_carry();
      test_back_to_back();
      test_reset_exec();
      test_sign();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width.
REQ-002 SHALL have port: clk  in  1  single clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports (i = 0,1): reqi_valid  in  1  requester i has an op pending.
REQ-005 SHALL have ports: reqi_ready  out  1  requester i's op accepted this cycle.
REQ-006 SHALL have ports: reqi_a, reqi_b  in  WIDTH  operands.
REQ-007 SHALL have ports: reqi_sel  in  1 (operand-mux select); reqi_op  in  5 (ALU opcode).
REQ-008 SHALL have ports: alu_a, alu_b  out  WIDTH; alu_sel  out  1; alu_op  out  5; all drive the shared ALU.
REQ-009 SHALL have ports: alu_result  in  WIDTH; alu_carry, alu_zero, alu_sign  in  1; all from the shared ALU.
REQ-010 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1 (requester index).
REQ-011 SHALL have ports: rsp_result  out  WIDTH; rsp_carry, rsp_zero, rsp_sign  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE: if any reqi_valid, SHALL assert exactly one reqi_ready (combinational), latch that requester's a/b/sel/op and index, and go to EXEC; otherwise stay in IDLE.
REQ-014 Both valid in IDLE: SHALL grant the requester named by the round-robin pointer; after every grant the pointer SHALL point to the other requester.
REQ-015 One valid in IDLE: SHALL grant it regardless of pointer; pointer still toggles to the other index.
REQ-016 reqi_ready SHALL be 0 in EXEC and RESP.
REQ-017 In EXEC: alu_* SHALL drive the latched operands for exactly one cycle; at the end of that cycle the ALU outputs SHALL be captured into rsp_*, and the FSM goes to RESP.
REQ-018 Outside EXEC: alu_a = alu_b = 0, alu_sel = 0, alu_op = 5'b00000 (pass).
REQ-019 rsp_carry SHALL equal captured alu_carry only when latched op == 5'b00001, else 0 (the ALU carry output is held over from earlier ops).
REQ-020 In RESP: rsp_valid = 1; rsp_* SHALL hold stable until rsp_ready = 1; on rsp_valid & rsp_ready, go to IDLE.
REQ-021 Latency: accept at edge N -> rsp_valid high from cycle N+2; minimum issue interval 3 cycles.
REQ-022 No new request SHALL be accepted in the cycle the response is consumed.
REQ-023 Opcodes SHALL pass unchanged; undefined opcodes are not filtered (the ALU returns 0).
REQ-024 rsp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, pointer 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp flags 0, req ready 0, alu_* per REQ-018.
REQ-026 Reset in EXEC or RESP SHALL discard the in-flight op without a response; the requester re-presents it.
REQ-027 The first accept after reset release SHALL be no earlier than the first rising edge with rst_n high.

Structure
REQ-028 Package alu_arb_pkg SHALL hold the state enum, ALU_OP_PASS = 5'b00000, and ALU_OP_ADDC = 5'b00001.
REQ-029 Sub-module rr_arb2 SHALL hold the 2-way round-robin grant logic and pointer; all other logic is flat.

Verification
REQ-030 Single op: req0 a=5, b=7, sel=0, op=00001 -> rsp_valid at N+2, id=0, result=12, carry=0, zero=0, sign=0.
REQ-031 Contention: both valid from reset, pointer=0 -> grant order req0, req1, req0; rsp_id sequence 0,1,0.
REQ-032 Carry gating: op=00001 with a=32'hFFFFFFFF, b=1 -> result=0, carry=1, zero=1; then op=00010 (AND) -> rsp_carry=0.
REQ-033 Backpressure: rsp_ready low 5 cycles -> rsp_* stable, req ready 0 throughout; accept resumes one cycle after the handshake.
REQ-034 Reset mid-EXEC: rst_n low during EXEC -> no rsp_valid; state IDLE, pointer 0; re-issued op completes normally.
REQ-035 Sign/zero: op=00101, sel=1, a=x, b=3 -> result=1+~3=32'hFFFFFFFD, sign=1, zero=0.
